// File: rtl/buffer_access_arbiter.sv
// Arbiter for the 64-byte endpoint buffer: enforces TX/RX direction, tracks
// occupancy, and issues exactly one registered buffer strobe per grant.
module buffer_access_arbiter #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             host_wr_req,
  input  logic             host_rd_req,
  input  logic             usb_wr_req,
  input  logic             usb_rd_req,
  input  logic             clear_req,
  input  logic             flush_req,
  output logic             host_ack,
  output logic             usb_ack,
  output logic             host_err,
  output logic             usb_err,
  output logic             store_tx_data,
  output logic             get_rx_data,
  output logic             store_rx_packet_data,
  output logic             get_tx_packet_data,
  output logic             clear,
  output logic             flush,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_TX   = 2'b01,
    M_RX   = 2'b10,
    M_RSVD = 2'b11
  } mode_t;

  mode_t            r_mode, w_mode_nx;
  logic [CNT_W-1:0] r_occ, w_occ_nx;
  logic             r_ptr, w_ptr_nx;  // 0: host wins the next contention
  logic             r_host_ack, r_usb_ack, r_host_err, r_usb_err;
  logic             r_st_tx, r_get_rx, r_st_rx, r_get_tx, r_clear, r_flush;
  logic             w_host_ack_nx, w_usb_ack_nx, w_host_err_nx, w_usb_err_nx;
  logic             w_st_tx_nx, w_get_rx_nx, w_st_rx_nx, w_get_tx_nx;
  logic             w_clear_nx, w_flush_nx;
  logic             w_h_wr, w_h_rd, w_u_wr, w_u_rd;
  logic             w_h_can, w_u_can, w_grant_h, w_grant_u;
  logic             w_not_full, w_not_empty;

  // A side that was answered last cycle sits out one edge; dual requests are ignored.
  assign w_h_wr = host_wr_req & ~host_rd_req & ~(r_host_ack | r_host_err);
  assign w_h_rd = host_rd_req & ~host_wr_req & ~(r_host_ack | r_host_err);
  assign w_u_wr = usb_wr_req  & ~usb_rd_req  & ~(r_usb_ack  | r_usb_err);
  assign w_u_rd = usb_rd_req  & ~usb_wr_req  & ~(r_usb_ack  | r_usb_err);

  assign w_not_full  = (r_occ < CNT_W'(DEPTH));
  assign w_not_empty = (r_occ != '0);

  always_comb begin
    w_mode_nx     = r_mode;
    w_occ_nx      = r_occ;
    w_ptr_nx      = r_ptr;
    w_host_ack_nx = 1'b0;
    w_usb_ack_nx  = 1'b0;
    w_host_err_nx = 1'b0;
    w_usb_err_nx  = 1'b0;
    w_st_tx_nx    = 1'b0;
    w_get_rx_nx   = 1'b0;
    w_st_rx_nx    = 1'b0;
    w_get_tx_nx   = 1'b0;
    w_clear_nx    = 1'b0;
    w_flush_nx    = 1'b0;
    w_h_can       = 1'b0;
    w_u_can       = 1'b0;
    w_grant_h     = 1'b0;
    w_grant_u     = 1'b0;
    if (clear_req || flush_req) begin
      w_clear_nx = clear_req;
      w_flush_nx = ~clear_req;
      w_occ_nx   = '0;
      w_mode_nx  = M_IDLE;
    end else begin
      case (r_mode)
        M_IDLE: begin
          w_h_can = w_h_wr;
          w_u_can = w_u_wr;
        end
        M_TX: begin
          w_h_can       = w_h_wr & w_not_full;
          w_u_can       = w_u_rd & w_not_empty;
          w_host_err_nx = w_h_rd;
          w_usb_err_nx  = w_u_wr;
        end
        M_RX: begin
          w_u_can       = w_u_wr & w_not_full;
          w_h_can       = w_h_rd & w_not_empty;
          w_host_err_nx = w_h_wr;
          w_usb_err_nx  = w_u_rd;
        end
        default: w_mode_nx = M_IDLE;
      endcase
      w_grant_h = w_h_can & (~w_u_can | ~r_ptr);
      w_grant_u = w_u_can & ~w_grant_h;
      // In IDLE only writes can be granted, so a write grant also sets direction.
      if (w_grant_h) begin
        w_host_ack_nx = 1'b1;
        w_ptr_nx      = 1'b1;
        if (w_h_wr) begin
          w_st_tx_nx = 1'b1;
          w_occ_nx   = r_occ + CNT_W'(1);
          w_mode_nx  = M_TX;
        end else begin
          w_get_rx_nx = 1'b1;
          w_occ_nx    = r_occ - CNT_W'(1);
          if (r_occ == CNT_W'(1)) w_mode_nx = M_IDLE;
        end
      end else if (w_grant_u) begin
        w_usb_ack_nx = 1'b1;
        w_ptr_nx     = 1'b0;
        if (w_u_wr) begin
          w_st_rx_nx = 1'b1;
          w_occ_nx   = r_occ + CNT_W'(1);
          w_mode_nx  = M_RX;
        end else begin
          w_get_tx_nx = 1'b1;
          w_occ_nx    = r_occ - CNT_W'(1);
          if (r_occ == CNT_W'(1)) w_mode_nx = M_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_mode     <= M_IDLE;
      r_occ      <= '0;
      r_ptr      <= 1'b0;
      r_host_ack <= 1'b0;
      r_usb_ack  <= 1'b0;
      r_host_err <= 1'b0;
      r_usb_err  <= 1'b0;
      r_st_tx    <= 1'b0;
      r_get_rx   <= 1'b0;
      r_st_rx    <= 1'b0;
      r_get_tx   <= 1'b0;
      r_clear    <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_mode     <= w_mode_nx;
      r_occ      <= w_occ_nx;
      r_ptr      <= w_ptr_nx;
      r_host_ack <= w_host_ack_nx;
      r_usb_ack  <= w_usb_ack_nx;
      r_host_err <= w_host_err_nx;
      r_usb_err  <= w_usb_err_nx;
      r_st_tx    <= w_st_tx_nx;
      r_get_rx   <= w_get_rx_nx;
      r_st_rx    <= w_st_rx_nx;
      r_get_tx   <= w_get_tx_nx;
      r_clear    <= w_clear_nx;
      r_flush    <= w_flush_nx;
    end
  end

  assign host_ack             = r_host_ack;
  assign usb_ack              = r_usb_ack;
  assign host_err             = r_host_err;
  assign usb_err              = r_usb_err;
  assign store_tx_data        = r_st_tx;
  assign get_rx_data          = r_get_rx;
  assign store_rx_packet_data = r_st_rx;
  assign get_tx_packet_data   = r_get_tx;
  assign clear                = r_clear;
  assign flush                = r_flush;
  assign mode                 = r_mode;
  assign occupancy            = r_occ;

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Directed bench for buffer_access_arbiter: fill/drain, full stall, alternation,
// direction errors, clear/flush priority and asynchronous reset.
module tb_buffer_access_arbiter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       host_wr_req, host_rd_req, usb_wr_req, usb_rd_req, clear_req, flush_req;
  logic       host_ack, usb_ack, host_err, usb_err;
  logic       store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data;
  logic       clear, flush;
  logic [1:0] mode;
  logic [6:0] occupancy;
  logic [5:0] strb;
  logic [18:0] outs;
  int         n_cmp = 0;
  int         n_bad = 0;

  buffer_access_arbiter #(.DEPTH(64), .CNT_W(7)) dut (
    .clk(clk), .n_rst(n_rst),
    .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
    .usb_wr_req(usb_wr_req), .usb_rd_req(usb_rd_req),
    .clear_req(clear_req), .flush_req(flush_req),
    .host_ack(host_ack), .usb_ack(usb_ack), .host_err(host_err), .usb_err(usb_err),
    .store_tx_data(store_tx_data), .get_rx_data(get_rx_data),
    .store_rx_packet_data(store_rx_packet_data), .get_tx_packet_data(get_tx_packet_data),
    .clear(clear), .flush(flush), .mode(mode), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // strobe order: store_tx, get_rx, store_rx, get_tx, clear, flush
  assign strb = {store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data, clear, flush};
  assign outs = {host_ack, usb_ack, host_err, usb_err, strb, mode, occupancy};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_req(input logic v);
    host_wr_req = v; host_rd_req = v; usb_wr_req = v;
    usb_rd_req  = v; clear_req   = v; flush_req  = v;
  endtask

  task automatic do_clear();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    set_all_req(1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (outs !== 19'h0) begin
        n_bad++; $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, outs);
      end
    end
    set_all_req(1'b0);
    n_rst = 1'b0;
    step();
  endtask

  task automatic test_tx_fill_drain();
    host_wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({host_ack, strb, mode, occupancy} !== {1'b1, 6'b100000, 2'b01, 7'(i + 1)}) begin
        n_bad++; $display("FAIL tx_write%0d: got ack=%b strb=%b mode=%b occ=%0d expected ack=1 strb=100000 mode=01 occ=%0d",
                          i, host_ack, strb, mode, occupancy, i + 1);
      end
      if (i < 2) step();
    end
    host_wr_req = 1'b0;
    step();
    usb_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({usb_ack, strb, mode, occupancy} !== {1'b1, 6'b000100, (i == 2) ? 2'b00 : 2'b01, 7'(2 - i)}) begin
        n_bad++; $display("FAIL tx_read%0d: got ack=%b strb=%b mode=%b occ=%0d expected ack=1 strb=000100 mode=%0d occ=%0d",
                          i, usb_ack, strb, mode, occupancy, (i == 2) ? 0 : 1, 2 - i);
      end
      if (i < 2) step();
    end
    usb_rd_req = 1'b0;
    step();
  endtask

  task automatic test_full_stall();
    logic stalled_ack;
    logic got;
    host_wr_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step(); step();
    end
    n_cmp++;
    if ({mode, occupancy} !== {2'b01, 7'd64}) begin
      n_bad++; $display("FAIL full_count: got mode=%b occ=%0d expected mode=01 occ=64", mode, occupancy);
    end
    stalled_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      stalled_ack = stalled_ack | host_ack | store_tx_data;
    end
    n_cmp++;
    if ({stalled_ack, occupancy} !== {1'b0, 7'd64}) begin
      n_bad++; $display("FAIL full_stall: got ack_seen=%b occ=%0d expected ack_seen=0 occ=64", stalled_ack, occupancy);
    end
    usb_rd_req = 1'b1;
    step();
    usb_rd_req = 1'b0;
    n_cmp++;
    if ({strb, host_ack, occupancy} !== {6'b000100, 1'b0, 7'd63}) begin
      n_bad++; $display("FAIL full_read: got strb=%b host_ack=%b occ=%0d expected strb=000100 host_ack=0 occ=63",
                        strb, host_ack, occupancy);
    end
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      step();
      if (host_ack === 1'b1) got = 1'b1;
    end
    host_wr_req = 1'b0;
    n_cmp++;
    if ({got, occupancy} !== {1'b1, 7'd64}) begin
      n_bad++; $display("FAIL full_resume: got acked=%b occ=%0d expected acked=1 occ=64", got, occupancy);
    end
    step();
  endtask

  task automatic test_alternate();
    do_clear();
    host_wr_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(); step();
    end
    host_wr_req = 1'b0;
    usb_rd_req  = 1'b1;
    step();
    usb_rd_req  = 1'b0;
    step();
    n_cmp++;
    if ({mode, occupancy} !== {2'b01, 7'd10}) begin
      n_bad++; $display("FAIL alt_setup: got mode=%b occ=%0d expected mode=01 occ=10", mode, occupancy);
    end
    host_wr_req = 1'b1;
    usb_rd_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if ({strb, occupancy} !== {(i % 2 == 0) ? 6'b100000 : 6'b000100, (i % 2 == 0) ? 7'd11 : 7'd10}) begin
        n_bad++; $display("FAIL alt_grant%0d: got strb=%b occ=%0d expected strb=%s occ=%0d",
                          i, strb, occupancy, (i % 2 == 0) ? "100000" : "000100", (i % 2 == 0) ? 11 : 10);
      end
    end
    host_wr_req = 1'b0;
    usb_rd_req  = 1'b0;
    step();
  endtask

  task automatic test_wrong_dir();
    usb_wr_req = 1'b1;
    step();
    usb_wr_req = 1'b0;
    n_cmp++;
    if ({usb_err, usb_ack, strb, occupancy} !== {1'b1, 1'b0, 6'b000000, 7'd10}) begin
      n_bad++; $display("FAIL tx_usb_wr_err: got err=%b ack=%b strb=%b occ=%0d expected err=1 ack=0 strb=000000 occ=10",
                        usb_err, usb_ack, strb, occupancy);
    end
    step();
    n_cmp++;
    if (usb_err !== 1'b0) begin
      n_bad++; $display("FAIL err_one_cycle: got usb_err=%b expected 0", usb_err);
    end
  endtask

  task automatic test_clear_flush_priority();
    do_clear();
    usb_wr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); step();
    end
    usb_wr_req = 1'b0;
    n_cmp++;
    if ({mode, occupancy} !== {2'b10, 7'd5}) begin
      n_bad++; $display("FAIL rx_setup: got mode=%b occ=%0d expected mode=10 occ=5", mode, occupancy);
    end
    host_rd_req = 1'b1;
    clear_req   = 1'b1;
    flush_req   = 1'b1;
    step();
    clear_req   = 1'b0;
    flush_req   = 1'b0;
    n_cmp++;
    if ({strb, host_ack, mode, occupancy} !== {6'b000010, 1'b0, 2'b00, 7'd0}) begin
      n_bad++; $display("FAIL clear_prio: got strb=%b host_ack=%b mode=%b occ=%0d expected strb=000010 host_ack=0 mode=00 occ=0",
                        strb, host_ack, mode, occupancy);
    end
    step();
    host_rd_req = 1'b0;
    n_cmp++;
    if ({host_ack, host_err, strb} !== 8'h00) begin
      n_bad++; $display("FAIL idle_read_stall: got ack=%b err=%b strb=%b expected all 0", host_ack, host_err, strb);
    end
  endtask

  task automatic test_idle_contention();
    host_wr_req = 1'b1;
    usb_wr_req  = 1'b1;
    step();
    host_wr_req = 1'b0;
    n_cmp++;
    if ({host_ack, usb_ack, strb, mode, occupancy} !== {1'b1, 1'b0, 6'b100000, 2'b01, 7'd1}) begin
      n_bad++; $display("FAIL idle_rr_host: got hack=%b uack=%b strb=%b mode=%b occ=%0d expected hack=1 uack=0 strb=100000 mode=01 occ=1",
                        host_ack, usb_ack, strb, mode, occupancy);
    end
    step();
    usb_wr_req = 1'b0;
    n_cmp++;
    if ({usb_err, strb, occupancy} !== {1'b1, 6'b000000, 7'd1}) begin
      n_bad++; $display("FAIL loser_err: got usb_err=%b strb=%b occ=%0d expected usb_err=1 strb=000000 occ=1",
                        usb_err, strb, occupancy);
    end
    step();
  endtask

  task automatic test_flush();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n_cmp++;
    if ({strb, mode, occupancy} !== {6'b000001, 2'b00, 7'd0}) begin
      n_bad++; $display("FAIL flush: got strb=%b mode=%b occ=%0d expected strb=000001 mode=00 occ=0", strb, mode, occupancy);
    end
  endtask

  task automatic test_dual_req_ignored();
    logic seen;
    seen = 1'b0;
    host_wr_req = 1'b1;
    host_rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      seen = seen | host_ack | host_err | (|strb);
    end
    host_wr_req = 1'b0;
    host_rd_req = 1'b0;
    n_cmp++;
    if ({seen, occupancy} !== {1'b0, 7'd0}) begin
      n_bad++; $display("FAIL dual_req: got activity=%b occ=%0d expected activity=0 occ=0", seen, occupancy);
    end
  endtask

  task automatic test_async_reset();
    host_wr_req = 1'b1;
    step();
    n_cmp++;
    if ({host_ack, occupancy} !== {1'b1, 7'd1}) begin
      n_bad++; $display("FAIL pre_reset_grant: got ack=%b occ=%0d expected ack=1 occ=1", host_ack, occupancy);
    end
    #2 n_rst = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 19'h0) begin
      n_bad++; $display("FAIL async_reset: got %h expected 0", outs);
    end
    host_wr_req = 1'b0;
    step();
    n_rst = 1'b0;
    step();
    n_cmp++;
    if (outs !== 19'h0) begin
      n_bad++; $display("FAIL post_reset_idle: got %h expected 0", outs);
    end
  endtask

  initial begin
    test_reset();
    test_tx_fill_drain();
    test_full_stall();
    test_alternate();
    test_wrong_dir();
    test_clear_flush_priority();
    test_idle_contention();
    test_flush();
    test_dual_req_ignored();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buffer_access_arbiter.md
Name: buffer_access_arbiter

Overview:
Sequences and arbitrates all accesses to the 64-byte endpoint data buffer.
- Two requesters share the buffer: the host side (AHB slave) and the USB side (protocol RX/TX logic).
- Enforces transfer direction (TX: host fills, USB drains; RX: USB fills, host drains).
- Grants at most one buffer operation per cycle and stalls on full/empty.
- Generates the buffer strobes: store_tx_data, get_tx_packet_data, store_rx_packet_data, get_rx_data, flush, clear.

Parameters:
DEPTH, 64, buffer capacity in bytes; occupancy saturates here.
CNT_W, 7, occupancy counter width; must hold 0..DEPTH.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset; asynchronous, active-high (asserted = 1)
host_wr_req  input  1  host requests one buffer write (TX data)
host_rd_req  input  1  host requests one buffer read (RX data)
usb_wr_req  input  1  USB side requests one buffer write (RX packet data)
usb_rd_req  input  1  USB side requests one buffer read (TX packet data)
clear_req  input  1  request a buffer clear
flush_req  input  1  request a buffer flush
host_ack  output  1  host request serviced this cycle
usb_ack  output  1  USB request serviced this cycle
host_err  output  1  host request rejected (wrong direction)
usb_err  output  1  USB request rejected (wrong direction)
store_tx_data  output  1  buffer write strobe, host data
get_rx_data  output  1  buffer read strobe, to host
store_rx_packet_data  output  1  buffer write strobe, USB data
get_tx_packet_data  output  1  buffer read strobe, to USB
clear  output  1  buffer clear pulse
flush  output  1  buffer flush pulse
mode  output  2  00 IDLE, 01 TX, 10 RX, 11 reserved
occupancy  output  CNT_W  arbiter's byte count

Behaviour:
- Clock and reset: one clock (clk); reset n_rst is asynchronous and active-high.
- Reset values: all outputs 0, mode=IDLE, occupancy=0, round-robin pointer = host.
- Registered outputs. Requests are sampled at edge k; the resulting strobe, ack and err are high for exactly one cycle, k to k+1.
- Handshake: request is a level held until ack or err.
  - A requester whose ack or err is high in the current cycle is ineligible at the next edge. One request therefore yields one operation.
  - Each requester asserts at most one of its wr/rd requests at a time. If both are high, the request is ignored with no ack and no err.
- At most one strobe (incl. clear/flush) is high in any cycle.
- Priority at each edge: clear_req > flush_req > data requests.
  - clear_req: clear=1 for one cycle, occupancy→0, mode→IDLE, no ack/err that cycle.
  - flush_req: same, but drives flush instead of clear.
  - clear_req and flush_req together: clear only.
- Mode state machine:
  - IDLE:
    - host_wr_req eligible → store_tx_data, host_ack, mode→TX, occupancy=1.
    - usb_wr_req eligible → store_rx_packet_data, usb_ack, mode→RX, occupancy=1.
    - Both eligible: round-robin pointer picks the winner; the loser stays pending and gets err next cycle (wrong direction).
    - Read requests in IDLE stall (no ack, no err).
  - TX:
    - Legal ops: host write (only if occupancy<DEPTH) and USB read (only if occupancy>0).
    - host_rd_req or usb_wr_req → err pulse on that side, no strobe.
  - RX:
    - Legal ops: USB write (only if occupancy<DEPTH) and host read (only if occupancy>0).
    - usb_rd_req or host_wr_req → err.
  - A read that brings occupancy to 0 returns mode to IDLE in the same update.
- Contention: when both sides hold legal, unblocked requests, grant the side not granted last; the pointer updates only on a grant. Full/empty-blocked requests do not consume a turn.
- Error vs grant: an err to one side and a grant to the other may occur in the same cycle.
- Occupancy arithmetic: +1 per write strobe, −1 per read strobe. Never wraps; guarded by the full/empty checks.
- Reset mid-operation: every output returns to its reset value immediately (asynchronous). Pending requests must be reissued.

Test Plan:
1. Assert n_rst for 2 cycles with all requests high → all outputs 0, mode=00, occupancy=0 throughout reset.
2. Hold host_wr_req for 3 grants, then usb_rd_req for 3 grants → 3 store_tx_data pulses with mode=01 and occupancy 1,2,3; then 3 get_tx_packet_data pulses with occupancy 2,1,0; mode=00 after the third read.
3. Perform 64 host writes, then hold host_wr_req → no ack, occupancy=64. Issue one usb_rd_req → get_tx_packet_data fires, occupancy=63, and the stalled host write is acked within 2 cycles.
4. TX mode with occupancy=10, host_wr_req and usb_rd_req held continuously → strobes alternate host/USB every grant; occupancy oscillates 11/10.
5. TX mode, assert usb_wr_req → usb_err high for 1 cycle, no strobe, occupancy unchanged.
6. RX mode with occupancy=5, host_rd_req pending, assert clear_req and flush_req together → clear=1 for 1 cycle, flush=0, no host_ack, occupancy=0, mode=00.
